// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback-stage register file.
// Holds the writeback source encodings and the load funct3 codes.
// Pure declarations; no logic, no timing.
package wb_regfile_pkg;

    // Writeback source select for non-load instructions
    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_PC4   = 2'b01,
        WB_IMMU  = 2'b10,
        WB_AUIPC = 2'b11
    } wb_sel_e;

    // Load funct3 encodings
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam int unsigned NUM_REGS = 32;

endpackage

// File: rtl/wb_regfile_load_extract.sv
// Load data extraction: picks the addressed byte/half out of an aligned word and extends it.
// Purely combinational, zero latency; no flow control.
// Ports: i_read_mem (raw aligned word), i_funct3 (load type), i_byte_off (addr[1:0]), o_data (result).
module wb_regfile_load_extract
    import wb_regfile_pkg::*;
(
    input  logic [31:0] i_read_mem,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_read_mem[7:0];
        case (i_byte_off)
            2'd0:    w_byte = i_read_mem[7:0];
            2'd1:    w_byte = i_read_mem[15:8];
            2'd2:    w_byte = i_read_mem[23:16];
            default: w_byte = i_read_mem[31:24];
        endcase
        // Halfword lane chosen by bit 1 only; misaligned bit 0 is ignored
        w_half = i_byte_off[1] ? i_read_mem[31:16] : i_read_mem[15:0];

        o_data = i_read_mem;
        case (i_funct3)
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'd0, w_byte};
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_data = {16'd0, w_half};
            // LW and undefined encodings pass the word through
            default: o_data = i_read_mem;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + 32x32 register file with write-through bypass and retired-instruction counter.
// Writes land on posedge (reads/bypass/wb_data combinational, zero latency); no backpressure.
// Ports: clk/rst, WB-slot controls and candidates in, rs1/rs2 read ports, wb_data/addr/we and instret out.
module wb_regfile #(
    parameter int unsigned RESET_CLEARS_REGS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  addr_wb_in,
    input  logic        werf_enable_in,
    input  logic [1:0]  wb_select_in,
    input  logic        load_in,
    input  logic [2:0]  load_funct3_in,
    input  logic [1:0]  byte_off_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] immu_in,
    input  logic [31:0] pc_plus_immu_in,
    input  logic [31:0] read_mem_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_addr_out,
    output logic        wb_we_out,
    output logic [63:0] instret_out
);
    import wb_regfile_pkg::*;

    logic [31:0] r_regs [NUM_REGS];
    logic [63:0] r_instret;
    logic [31:0] w_load_data;
    logic [31:0] w_src_data;
    logic        w_we;

    wb_regfile_load_extract u_load_extract (
        .i_read_mem (read_mem_in),
        .i_funct3   (load_funct3_in),
        .i_byte_off (byte_off_in),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_src_data = alu_result_in;
        case (wb_sel_e'(wb_select_in))
            WB_ALU:   w_src_data = alu_result_in;
            WB_PC4:   w_src_data = pc_plus_4_in;
            WB_IMMU:  w_src_data = immu_in;
            WB_AUIPC: w_src_data = pc_plus_immu_in;
            default:  w_src_data = alu_result_in;
        endcase
    end

    assign wb_data_out = load_in ? w_load_data : w_src_data;
    assign wb_addr_out = addr_wb_in;
    assign w_we        = valid_in & werf_enable_in & (addr_wb_in != 5'd0);
    assign wb_we_out   = w_we;

    // Entry 0 is never written, so x0 stays architecturally zero via the read mux
    generate
        if (RESET_CLEARS_REGS != 0) begin : g_rst_regs
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        r_regs[i] <= '0;
                    end
                end else if (w_we) begin
                    r_regs[addr_wb_in] <= wb_data_out;
                end
            end
        end else begin : g_keep_regs
            // Contents survive reset, but a write during reset is still dropped
            always_ff @(posedge clk) begin
                if (w_we && !rst) begin
                    r_regs[addr_wb_in] <= wb_data_out;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (valid_in) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret_out = r_instret;

    // Write-through bypass so a same-cycle reader sees the value being written
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs2_data = r_regs[rs2_addr];
        if (w_we && (rs1_addr == addr_wb_in)) rs1_data = wb_data_out;
        if (w_we && (rs2_addr == addr_wb_in)) rs2_data = wb_data_out;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter RESET_CLEARS_REGS, default 1: 1 = all 31 writable registers cleared by reset; 0 = register contents untouched by reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  WB-stage slot holds a real instruction (not a bubble).
REQ-005 addr_wb_in  input  5  destination register index.
REQ-006 werf_enable_in  input  1  register-file write enable from decode.
REQ-007 wb_select_in  input  2  writeback source select for non-loads.
REQ-008 load_in  input  1  instruction is a load; memory data selected.
REQ-009 load_funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 byte_off_in  input  2  address bits [1:0] of the load.
REQ-011 pc_plus_4_in, immu_in, pc_plus_immu_in, read_mem_in, alu_result_in  input  32 each  writeback candidates; read_mem_in is the raw aligned word.
REQ-012 rs1_addr, rs2_addr  input  5 each  read-port indices.
REQ-013 rs1_data, rs2_data  output  32 each  read-port data.
REQ-014 wb_data_out  output  32  selected, load-extracted writeback value.
REQ-015 wb_addr_out  output  5  equals addr_wb_in.
REQ-016 wb_we_out  output  1  effective write strobe (for forwarding logic).
REQ-017 instret_out  output  64  retired-instruction count.

Function
REQ-018 Source mux: load_in=1 -> extracted memory data; else wb_select_in 00 alu_result_in, 01 pc_plus_4_in, 10 immu_in, 11 pc_plus_immu_in.
REQ-019 Byte extract: lane = read_mem_in[8*byte_off_in +: 8]; LB sign-extends, LBU zero-extends.
REQ-020 Half extract: byte_off_in[1]=0 -> bits[15:0], 1 -> bits[31:16]; LH sign-extends, LHU zero-extends; byte_off_in[0] ignored.
REQ-021 LW returns read_mem_in unchanged regardless of byte_off_in; undefined funct3 (011,110,111) returns read_mem_in.
REQ-022 wb_we_out = valid_in & werf_enable_in & (addr_wb_in != 0); combinational.
REQ-023 On posedge with wb_we_out=1, regs[addr_wb_in] <= wb_data_out; no other register changes.
REQ-024 x0 reads 0 always; writes to x0 discarded.
REQ-025 Reads combinational; when rsN_addr == addr_wb_in and wb_we_out=1, rsN_data returns wb_data_out in the same cycle (write-through bypass); rs1/rs2 equal addresses both bypass.
REQ-026 instret_out increments by 1 on each posedge with valid_in=1, independent of werf_enable_in; wraps 2^64-1 -> 0.
REQ-027 wb_data_out and wb_addr_out are combinational; zero-latency from inputs.

Reset
REQ-028 rst=1 clears instret_out to 0 immediately, independent of clk.
REQ-029 With RESET_CLEARS_REGS=1, rst=1 clears x1..x31 to 0 immediately; a write coincident with rst is dropped.
REQ-030 After rst deasserts, first posedge with wb_we_out=1 performs a normal write.

Structure
REQ-031 Shared package holds wb_select encodings (WB_ALU, WB_PC4, WB_IMMU, WB_AUIPC) and load funct3 constants.
REQ-032 One sub-module, load_extract: purely combinational read_mem_in/funct3/byte_off -> 32-bit result.

Verification
REQ-033 LB, byte_off=3, read_mem=0x80FF_1234 -> wb_data_out=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 LH, byte_off=2, read_mem=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LH byte_off=0 -> 0x0000_7FFF.
REQ-035 valid=1, we=1, addr=5, wb_select=10, immu=0x12345000, rs1_addr=5 same cycle -> rs1_data=0x12345000 before edge; after edge persists with inputs idle.
REQ-036 Write 0xDEADBEEF to addr 0 -> wb_we_out=0, rs2_addr=0 reads 0.
REQ-037 valid=0, we=1, addr=7 -> x7 unchanged, instret unchanged; 10 valid cycles -> instret_out=10.
REQ-038 Assert rst mid-clock after x3=0xA5A5A5A5, instret=4 -> x3=0 and instret_out=0 before next edge.
